// File: rtl/car_motion_ctrl.sv
// car_motion_ctrl
// Horizontal motion controller for the player car. Keeps a registered
// position, a speed magnitude and a heading. On every move tick the speed
// ramps toward the requested direction, coasts down when nothing (or the
// opposite way) is requested, and the position is clamped to the track
// bounds with a one-cycle bump pulse when a clamp happens.

module car_motion_ctrl #(
  parameter int X_WIDTH = 9,
  parameter int X_MIN   = 6,
  parameter int X_MAX   = 290,
  parameter int X_RESET = 150,
  parameter int V_WIDTH = 4,
  parameter int V_MAX   = 8,
  parameter int ACCEL   = 1,
  parameter int DECEL   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               can_move,
  input  logic               left_req,
  input  logic               right_req,
  input  logic [V_WIDTH-1:0] speed_cap,
  output logic [X_WIDTH-1:0] car_x,
  output logic [V_WIDTH-1:0] velocity,
  output logic [1:0]         heading,
  output logic [1:0]         direction,
  output logic               at_left_edge,
  output logic               at_right_edge,
  output logic               bumped
);

  // Shared encoding for heading and direction.
  typedef enum logic [1:0] {
    DIR_NONE  = 2'b00,
    DIR_LEFT  = 2'b01,
    DIR_RIGHT = 2'b10
  } dir_e;

  localparam int PW = X_WIDTH + 2;

  localparam logic [V_WIDTH-1:0]   VMaxW   = V_WIDTH'(V_MAX);
  localparam logic [V_WIDTH-1:0]   AccelW  = V_WIDTH'(ACCEL);
  localparam logic [V_WIDTH-1:0]   DecelW  = V_WIDTH'(DECEL);
  localparam logic [X_WIDTH-1:0]   XMinW   = X_WIDTH'(X_MIN);
  localparam logic [X_WIDTH-1:0]   XMaxW   = X_WIDTH'(X_MAX);
  localparam logic [X_WIDTH-1:0]   XResetW = X_WIDTH'(X_RESET);
  localparam logic signed [PW-1:0] XMinS   = PW'(X_MIN);
  localparam logic signed [PW-1:0] XMaxS   = PW'(X_MAX);

  logic [X_WIDTH-1:0] carX_q, carX_d;
  logic [V_WIDTH-1:0] velocity_q, velocity_d;
  dir_e               heading_q, heading_d;
  dir_e               direction_q, direction_d;
  logic               bumped_q, bumped_d;

  logic [V_WIDTH-1:0]   capV;
  logic [V_WIDTH-1:0]   vIn;
  logic [V_WIDTH:0]     vUp;
  logic [V_WIDTH-1:0]   vDown;
  logic [V_WIDTH-1:0]   vStart;
  logic [V_WIDTH-1:0]   vRule;
  dir_e                 headRule;
  logic signed [PW-1:0] basePos;
  logic signed [PW-1:0] step;
  logic signed [PW-1:0] nextPos;

  // State register: reset first, otherwise take the next-state values.
  always_ff @(posedge clk) begin
    if (reset) begin
      carX_q      <= XResetW;
      velocity_q  <= '0;
      heading_q   <= DIR_NONE;
      direction_q <= DIR_NONE;
      bumped_q    <= 1'b0;
    end else begin
      carX_q      <= carX_d;
      velocity_q  <= velocity_d;
      heading_q   <= heading_d;
      direction_q <= direction_d;
      bumped_q    <= bumped_d;
    end
  end

  // Next state: request decode every cycle, velocity/position only on a move tick.
  always_comb begin
    direction_d = DIR_NONE;
    if (left_req && !right_req) begin
      direction_d = DIR_LEFT;
    end else if (right_req && !left_req) begin
      direction_d = DIR_RIGHT;
    end

    capV   = (speed_cap > VMaxW) ? VMaxW : speed_cap;
    vIn    = (velocity_q > capV) ? capV : velocity_q;
    vUp    = {1'b0, vIn} + {1'b0, AccelW};
    vDown  = (vIn >= DecelW) ? (vIn - DecelW) : '0;
    vStart = (AccelW > capV) ? capV : AccelW;

    vRule    = vDown;
    headRule = heading_q;
    if (heading_q == DIR_NONE && direction_q != DIR_NONE) begin
      headRule = direction_q;
      vRule    = vStart;
    end else if (heading_q != DIR_NONE && direction_q == heading_q) begin
      vRule = (vUp > {1'b0, capV}) ? capV : vUp[V_WIDTH-1:0];
    end
    if (vRule == '0) begin
      headRule = DIR_NONE;
    end

    basePos = $signed({2'b00, carX_q});
    step    = $signed({{(PW-V_WIDTH){1'b0}}, vRule});
    nextPos = basePos;
    if (headRule == DIR_LEFT) begin
      nextPos = basePos - step;
    end else if (headRule == DIR_RIGHT) begin
      nextPos = basePos + step;
    end

    carX_d     = carX_q;
    velocity_d = velocity_q;
    heading_d  = heading_q;
    bumped_d   = 1'b0;
    if (can_move) begin
      if (nextPos < XMinS) begin
        carX_d     = XMinW;
        velocity_d = '0;
        heading_d  = DIR_NONE;
        bumped_d   = 1'b1;
      end else if (nextPos > XMaxS) begin
        carX_d     = XMaxW;
        velocity_d = '0;
        heading_d  = DIR_NONE;
        bumped_d   = 1'b1;
      end else begin
        carX_d     = nextPos[X_WIDTH-1:0];
        velocity_d = vRule;
        heading_d  = headRule;
      end
    end
  end

  // Outputs: registered state plus edge flags decoded from the position.
  always_comb begin
    car_x         = carX_q;
    velocity      = velocity_q;
    heading       = heading_q;
    direction     = direction_q;
    bumped        = bumped_q;
    at_left_edge  = (carX_q == XMinW);
    at_right_edge = (carX_q == XMaxW);
  end

endmodule

// File: tb/tb_car_motion_ctrl.sv
// tb_car_motion_ctrl
// Scoreboard bench: the driver applies one input set per cycle, advances a
// plain-integer model of the car and queues the expected post-edge outputs;
// a monitor pops one entry after every rising edge and compares.

module tb_car_motion_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       can_move;
  logic       left_req;
  logic       right_req;
  logic [3:0] speed_cap;
  logic [8:0] car_x;
  logic [3:0] velocity;
  logic [1:0] heading;
  logic [1:0] direction;
  logic       at_left_edge;
  logic       at_right_edge;
  logic       bumped;

  typedef struct {
    int         x;
    int         v;
    logic [1:0] h;
    logic [1:0] d;
    logic       b;
  } exp_t;

  exp_t expQ[$];

  // Model state: position, speed, heading/direction as -1/0/+1, bump flag.
  int   mx, mv, mh, md;
  logic mb;

  int checkCount = 0;
  int failCount  = 0;

  car_motion_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .can_move     (can_move),
    .left_req     (left_req),
    .right_req    (right_req),
    .speed_cap    (speed_cap),
    .car_x        (car_x),
    .velocity     (velocity),
    .heading      (heading),
    .direction    (direction),
    .at_left_edge (at_left_edge),
    .at_right_edge(at_right_edge),
    .bumped       (bumped)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic logic [1:0] encDir(input int s);
    if (s < 0) return 2'b01;
    if (s > 0) return 2'b10;
    return 2'b00;
  endfunction

  task automatic checkOutput(input string name, input int act, input int req);
    checkCount++;
    if (act != req) begin
      failCount++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs, step the model to the state after the coming edge.
  task automatic applyStimulus(input logic r, input logic cm, input logic l,
                               input logic rq, input logic [3:0] cap);
    int   c;
    int   nx;
    exp_t e;
    @(negedge clk);
    reset     = r;
    can_move  = cm;
    left_req  = l;
    right_req = rq;
    speed_cap = cap;
    if (r) begin
      mx = 150; mv = 0; mh = 0; md = 0; mb = 1'b0;
    end else begin
      mb = 1'b0;
      if (cm) begin
        c = (int'(cap) > 8) ? 8 : int'(cap);
        if (mv > c) mv = c;
        if (mh == 0 && md != 0) begin
          mh = md;
          mv = (c < 1) ? c : 1;
        end else if (md != 0 && md == mh) begin
          mv = (mv + 1 > c) ? c : mv + 1;
        end else begin
          mv = (mv > 1) ? mv - 1 : 0;
        end
        if (mv == 0) mh = 0;
        nx = mx + mh * mv;
        if (nx < 6) begin
          mx = 6; mv = 0; mh = 0; mb = 1'b1;
        end else if (nx > 290) begin
          mx = 290; mv = 0; mh = 0; mb = 1'b1;
        end else begin
          mx = nx;
        end
      end
      md = (l && !rq) ? -1 : ((rq && !l) ? 1 : 0);
    end
    e.x = mx;
    e.v = mv;
    e.h = encDir(mh);
    e.d = encDir(md);
    e.b = mb;
    expQ.push_back(e);
  endtask

  // Monitor: after each rising edge compare the DUT against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("car_x", int'(car_x), e.x);
        checkOutput("velocity", int'(velocity), e.v);
        checkOutput("heading", int'(heading), int'(e.h));
        checkOutput("direction", int'(direction), int'(e.d));
        checkOutput("bumped", int'(bumped), int'(e.b));
        checkOutput("at_left_edge", int'(at_left_edge), (e.x == 6) ? 1 : 0);
        checkOutput("at_right_edge", int'(at_right_edge), (e.x == 290) ? 1 : 0);
      end
    end
  end

  // Directed scenarios followed by randomized held-request traffic.
  initial begin
    logic       rl, rr, rc, rst;
    logic [3:0] rcap;
    reset = 1'b1; can_move = 1'b0; left_req = 1'b0; right_req = 1'b0; speed_cap = 4'd8;

    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd8);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd8);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd3);
    repeat (5) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd3);

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd3);
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd3);

    repeat (45) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd8);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd8);
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd8);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'd8);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'd8);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd8);
    repeat (6) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd8);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd2);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'd8);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd8);

    repeat (60) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd8);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd8);

    rl = 1'b0; rr = 1'b1; rcap = 4'd8;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        rl = 1'($urandom_range(0, 1));
        rr = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 49) == 0) rcap = 4'($urandom_range(0, 15));
      rc  = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 299) == 0);
      applyStimulus(rst, rc, rl, rr, rcap);
    end

    repeat (3) @(posedge clk);
    #2;
    checkCount++;
    if (expQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL scoreboard_drain actual=%0d required=0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
